vmu_issue_rx: RTL
=================

Name: vmu_issue_rx

Overview:
- Receiving end of the sequencer's VMU issue interface (issue_vld plus op_config, scalar_config, op_ls and scalar_ls).
- Buffers issued bundles in order, with no backpressure toward the sequencer.
- Applies config ops, then expands each load/store op into a stream of per-beat memory requests with a valid/ready handshake.
- Reports free-entry credits so the sequencer can throttle, and pulses a completion strobe per finished load/store.

Parameters:
- CONFIG_OP_WIDTH, 8, width of the config opcode.
- LSU_OP_WIDTH, 8, width of the load/store opcode.
- SCALAR_WIDTH, 64, width of the scalar operands.
- FIFO_DEPTH, 8, issue buffer entries; must be a power of 2 and at least 2.
- ADDR_WIDTH, 32, memory request address width.
- BEAT_BYTES, 64, address stride per beat.
- VLEN_WIDTH, 16, beat-count register width.
- DEFAULT_VLEN, 64, reset value of the beat count.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- i_seq_vmu_issue_vld, in, 1: issue strobe.
- i_seq_vmu_op_config, in, CONFIG_OP_WIDTH: config opcode; nonzero means set beat count.
- i_seq_vmu_scalar_config, in, SCALAR_WIDTH: new beat count; low VLEN_WIDTH bits are used.
- i_seq_vmu_op_ls, in, LSU_OP_WIDTH: bits [1:0] encode 00 none, 01 load, 10 store, 11 illegal.
- i_seq_vmu_scalar_ls, in, SCALAR_WIDTH: base address; low ADDR_WIDTH bits are used.
- o_credit, out, $clog2(FIFO_DEPTH)+1: free FIFO entries.
- o_mem_req_vld, out, 1: memory request valid.
- i_mem_req_rdy, in, 1: memory request ready.
- o_mem_req_we, out, 1: 1 for store, 0 for load.
- o_mem_req_addr, out, ADDR_WIDTH: beat address.
- o_mem_req_last, out, 1: final beat of the current op.
- o_done, out, 1: one-cycle pulse per completed load/store.
- o_done_cnt, out, 16: completed load/store count, wrapping.
- o_ovf_err, out, 1: sticky; set when an issue is dropped because the FIFO is full.
- o_op_err, out, 1: sticky; set when an illegal ls encoding is popped.
- o_busy, out, 1: FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset (rst high at a clk edge) clears the FIFO, returns the FSM to IDLE, sets vlen=DEFAULT_VLEN, and sets every output to 0 except o_credit=FIFO_DEPTH. Reset mid-burst aborts the burst immediately; no o_done is produced for the aborted op.
- Push: on i_seq_vmu_issue_vld, the whole bundle is written to the FIFO tail. Push is accepted if count<FIFO_DEPTH or a pop occurs in the same cycle. Otherwise the bundle is dropped, o_ovf_err is set, and count is unchanged.
- o_credit = FIFO_DEPTH - count, registered. It updates the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- Entries are retired strictly in issue order.
- FSM states are IDLE, RUN and DONE.
- IDLE, FIFO non-empty: pop the head. If op_config!=0, vlen <= scalar_config[VLEN_WIDTH-1:0], and this new value governs the same entry's ls op. Then dispatch on the ls field:
  - ls=00: stay in IDLE; the next pop can occur the following cycle, so throughput is 1 config entry per cycle.
  - ls=01 or 10, new vlen!=0: latch base and we, set beat=0, go to RUN.
  - ls=01 or 10, new vlen==0: go directly to DONE; no requests are issued.
  - ls=11: set o_op_err, apply the config part, discard the ls part, stay in IDLE.
- RUN: o_mem_req_vld=1.
  - o_mem_req_addr = (base + beat*BEAT_BYTES) mod 2^ADDR_WIDTH; address wrap-around is permitted silently.
  - o_mem_req_last = (beat==vlen_latched-1).
  - vld, addr and we stay stable while rdy=0.
  - On rdy: beat++. If last, go to DONE.
  - The first request is valid the cycle after the pop. A full-rate burst of N beats takes N cycles.
- DONE: o_done=1 for exactly one cycle, o_done_cnt increments (16-bit wrap), then go to IDLE. The next pop can occur the cycle after DONE.
- Issues arriving during RUN or DONE are buffered; they are never lost unless the FIFO is full.
- vlen changes arriving in later entries do not affect an op already in RUN.

Decomposition:
- Shared package vmu_rx_pkg:
  - ls encoding constants: LS_NONE, LS_LOAD, LS_STORE, LS_ILL.
  - Packed struct issue_bundle_t: op_config, scalar_config, op_ls, scalar_ls.
  - FSM state enum {IDLE, RUN, DONE}.
- One sub-module: vmu_issue_fifo, a synchronous FIFO of issue_bundle_t with push/pop, count, and full/empty flags, implementing the pop-enables-push-when-full rule.
- FSM and address generator live in vmu_issue_rx.

Test Plan:
- After reset with vlen=64: issue a load, base 0x1000, rdy=1 -> 64 beats at addr 0x1000, 0x1040, ..., 0x1FC0; last on beat 63, we=0; o_done one cycle after the last beat; o_done_cnt=1.
- Issue config=1 with scalar 3 plus store base 0x0 in one bundle, with rdy toggling 1,0,1,0,1 -> 3 beats, we=1, addresses 0x0/0x40/0x80 held stable while rdy=0, last on the 3rd beat.
- Hold rdy=0 during a burst and issue 9 bundles with FIFO_DEPTH=8 -> o_credit decrements to 0; the 9th bundle is dropped; o_ovf_err=1 and stays set; the 8 buffered ops then complete in order.
- Config with scalar 0 plus load -> no o_mem_req_vld; o_done pulses; o_done_cnt increments.
- Bundle with ls=11 and config=5 -> o_op_err=1, vlen=5, no done; a following load produces 5 beats.
- Assert rst during beat 10 of a 64-beat burst -> next cycle: o_mem_req_vld=0, o_credit=8, o_done_cnt=0, vlen=64, no o_done pulse.
- Base 0xFFFFFFC0, vlen=2 -> addresses 0xFFFFFFC0, then 0x00000000.

Source files
------------

// File: rtl/vmu_rx_pkg.sv
// Shared types for the VMU issue receiver: ls encodings, issue bundle layout, FSM states.
// Field widths here must match the vmu_issue_rx width parameters.
package vmu_rx_pkg;

    localparam int CONFIG_OP_W = 8;
    localparam int LSU_OP_W    = 8;
    localparam int SCALAR_W    = 64;

    localparam logic [1:0] LS_NONE  = 2'b00;
    localparam logic [1:0] LS_LOAD  = 2'b01;
    localparam logic [1:0] LS_STORE = 2'b10;
    localparam logic [1:0] LS_ILL   = 2'b11;

    typedef struct packed {
        logic [CONFIG_OP_W-1:0] op_config;
        logic [SCALAR_W-1:0]    scalar_config;
        logic [LSU_OP_W-1:0]    op_ls;
        logic [SCALAR_W-1:0]    scalar_ls;
    } issue_bundle_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vmu_issue_fifo.sv
// In-order buffer of issue bundles; a pop in the same cycle frees room for a push when full.
// Free-entry count is kept as its own register so the credit output comes straight from a flop.
module vmu_issue_fifo
    import vmu_rx_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  issue_bundle_t              i_push_data,
    input  logic                       i_pop,
    output issue_bundle_t              o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(DEPTH):0]     o_free,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_push_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    issue_bundle_t r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_free;
    logic          w_push;
    logic          w_pop;

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_pop       = i_pop && !o_empty;
    assign w_push      = i_push && (!o_full || w_pop);
    assign o_push_drop = i_push && !w_push;
    assign o_head      = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_free      = r_free;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_free   <= CW'(DEPTH);
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10: begin
                    r_count <= r_count + CW'(1);
                    r_free  <= r_free - CW'(1);
                end
                2'b01: begin
                    r_count <= r_count - CW'(1);
                    r_free  <= r_free + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vmu_issue_rx.sv
// VMU issue receiver: buffers issued bundles, applies config ops and expands
// each load/store into per-beat memory requests, with credits and completion strobes.
module vmu_issue_rx
    import vmu_rx_pkg::*;
#(
    parameter int CONFIG_OP_WIDTH = 8,
    parameter int LSU_OP_WIDTH    = 8,
    parameter int SCALAR_WIDTH    = 64,
    parameter int FIFO_DEPTH      = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int BEAT_BYTES      = 64,
    parameter int VLEN_WIDTH      = 16,
    parameter int DEFAULT_VLEN    = 64
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_seq_vmu_issue_vld,
    input  logic [CONFIG_OP_WIDTH-1:0]    i_seq_vmu_op_config,
    input  logic [SCALAR_WIDTH-1:0]       i_seq_vmu_scalar_config,
    input  logic [LSU_OP_WIDTH-1:0]       i_seq_vmu_op_ls,
    input  logic [SCALAR_WIDTH-1:0]       i_seq_vmu_scalar_ls,
    output logic [$clog2(FIFO_DEPTH):0]   o_credit,
    output logic                          o_mem_req_vld,
    input  logic                          i_mem_req_rdy,
    output logic                          o_mem_req_we,
    output logic [ADDR_WIDTH-1:0]         o_mem_req_addr,
    output logic                          o_mem_req_last,
    output logic                          o_done,
    output logic [15:0]                   o_done_cnt,
    output logic                          o_ovf_err,
    output logic                          o_op_err,
    output logic                          o_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    issue_bundle_t          w_push_data;
    issue_bundle_t          w_head;
    logic [CW-1:0]          w_count;
    logic [CW-1:0]          w_free;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_drop;
    logic                   w_pop;
    logic [1:0]             w_ls;
    logic                   w_is_ls;
    logic                   w_last;
    logic [VLEN_WIDTH-1:0]  w_new_vlen;
    logic                   w_unused;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [VLEN_WIDTH-1:0]  r_vlen;
    logic [VLEN_WIDTH-1:0]  r_vlen_lat;
    logic [VLEN_WIDTH-1:0]  r_beat;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_we;
    logic [15:0]            r_done_cnt;
    logic                   r_ovf_err;
    logic                   r_op_err;

    assign w_push_data = {i_seq_vmu_op_config, i_seq_vmu_scalar_config,
                          i_seq_vmu_op_ls, i_seq_vmu_scalar_ls};

    vmu_issue_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (i_seq_vmu_issue_vld),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_free      (w_free),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_push_drop (w_drop)
    );

    // A config in the popped entry takes effect for that same entry's ls op.
    assign w_ls       = w_head.op_ls[1:0];
    assign w_is_ls    = (w_ls == LS_LOAD) || (w_ls == LS_STORE);
    assign w_new_vlen = (w_head.op_config != '0) ? w_head.scalar_config[VLEN_WIDTH-1:0] : r_vlen;
    assign w_last     = (r_beat == r_vlen_lat - VLEN_WIDTH'(1));

    assign w_unused = ^{w_full, w_head.op_ls[LSU_OP_WIDTH-1:2],
                        w_head.scalar_config[SCALAR_WIDTH-1:VLEN_WIDTH],
                        w_head.scalar_ls[SCALAR_WIDTH-1:ADDR_WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pop          = 1'b0;
        o_mem_req_vld  = 1'b0;
        o_mem_req_last = 1'b0;
        o_done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_is_ls) begin
                        w_state_next = (w_new_vlen != '0) ? RUN : DONE;
                    end
                end
            end
            RUN: begin
                o_mem_req_vld  = 1'b1;
                o_mem_req_last = w_last;
                if (i_mem_req_rdy && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Address advances by one stride per accepted beat; wrap-around is intentional.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vlen     <= VLEN_WIDTH'(DEFAULT_VLEN);
            r_vlen_lat <= '0;
            r_beat     <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_done_cnt <= '0;
            r_ovf_err  <= 1'b0;
            r_op_err   <= 1'b0;
        end else begin
            if (w_drop) r_ovf_err <= 1'b1;
            if (w_pop) begin
                r_vlen <= w_new_vlen;
                if (w_ls == LS_ILL) r_op_err <= 1'b1;
                if (w_is_ls) begin
                    r_vlen_lat <= w_new_vlen;
                    r_beat     <= '0;
                    r_addr     <= w_head.scalar_ls[ADDR_WIDTH-1:0];
                    r_we       <= (w_ls == LS_STORE);
                end
            end
            if ((r_state == RUN) && i_mem_req_rdy) begin
                r_beat <= r_beat + VLEN_WIDTH'(1);
                r_addr <= r_addr + ADDR_WIDTH'(BEAT_BYTES);
            end
            if (r_state == DONE) r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

    assign o_credit       = w_free;
    assign o_mem_req_we   = r_we;
    assign o_mem_req_addr = r_addr;
    assign o_done_cnt     = r_done_cnt;
    assign o_ovf_err      = r_ovf_err;
    assign o_op_err       = r_op_err;
    assign o_busy         = (w_count != '0) || (r_state != IDLE);

endmodule
